mu0_control: RTL and testbench
==============================

# mu0_control

MU0 control unit: a fetch/execute state machine that consumes the opcode and flags produced by `mu0_datapath` (`F`, `N`, `Z`) and drives every datapath select, enable and ALU-mode line. It also sequences memory accesses through a request/acknowledge handshake, so memory of any latency can be used. It halts on `STP` or on an illegal opcode, and it counts retired instructions for debug and verification.

## Interface
- No parameters.
- `Clk` in 1 — system clock; all state changes on the rising edge.
- `Reset` in 1 — asynchronous, active-high.
- `F` in 4 — opcode, `IR[15:12]` from the datapath.
- `N` in 1 — accumulator-negative flag.
- `Z` in 1 — accumulator-zero flag.
- `Mem_Ack` in 1 — memory completes the current `Mem_Rd`/`Mem_Wr`.
  - Ignored when neither request is asserted.
  - May be asserted in the same cycle as the request.
- `X_sel` out 1 — 0 = Acc, 1 = PC.
- `Y_sel` out 1 — 0 = Data_in, 1 = IR.
- `Addr_sel` out 1 — 0 = PC, 1 = IR[11:0].
- `PC_En` out 1 — PC load enable.
- `IR_En` out 1 — IR load enable.
- `Acc_En` out 1 — accumulator load enable.
- `M` out 2 — ALU mode: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X−Y.
- `Mem_Rd` out 1 — memory read request.
- `Mem_Wr` out 1 — memory write request; write data is `Data_out` (= X).
- `Halted` out 1 — high in HALT.
- `Illegal` out 1 — sticky; set when an opcode 8–F is executed.
- `Instr_Count` out 16 — number of retired instructions.

## Operation
- States: FETCH, EXECUTE, HALT.
- Outputs are decoded from state and `F`.
- Register enables are additionally gated by `Mem_Ack` in memory states (Mealy).
- FETCH
  - Drives: Addr_sel=0, Mem_Rd=1, X_sel=1, M=10.
  - On `Mem_Ack`: IR_En=1 and PC_En=1, giving PC := PC+1. Next state is EXECUTE.
  - Without `Mem_Ack`: stays in FETCH with all enables 0.
- EXECUTE, by `F`:
  - 0 LDA: Addr_sel=1, Mem_Rd, Y_sel=0, M=00; Acc_En on ack.
  - 1 STO: Addr_sel=1, Mem_Wr, X_sel=0; no register enable.
  - 2 ADD: Addr_sel=1, Mem_Rd, X_sel=0, Y_sel=0, M=01; Acc_En on ack.
  - 3 SUB: as ADD but M=11.
  - 4 JMP: Y_sel=1, M=00, PC_En=1. No memory access; completes in one cycle.
  - 5 JGE: as JMP but PC_En=~N.
  - 6 JNE: as JMP but PC_En=~Z.
  - 7 STP: no enables; next state HALT.
  - 8–F: no enables; set `Illegal`; next state HALT.
- Memory ops remain in EXECUTE until `Mem_Ack`, then return to FETCH.
- Jumps return to FETCH immediately.
- A not-taken conditional leaves PC at the already-incremented value.
- `Instr_Count` increments by 1 when leaving EXECUTE for FETCH, and on entry to HALT via STP. It wraps from FFFF to 0000 and does not count illegal opcodes.
- HALT: every output is 0 except `Halted`, `Illegal` and `Instr_Count`. HALT persists until Reset; `Mem_Ack` is ignored.
- `Mem_Rd` and `Mem_Wr` are never asserted together.
- Unused selects are driven to 0; they are not left as don't-care.

## Timing
- While `Reset` is high:
  - State = FETCH, `Instr_Count`=0, `Illegal`=0, `Halted`=0.
  - All enables, `Mem_Rd` and `Mem_Wr` are forced to 0.
- First cycle after release: FETCH with `Mem_Rd`=1, Addr_sel=0.
- Reset asserted mid-access aborts the access immediately. No register enable is produced in that cycle.
- Latency with zero-wait memory (`Mem_Ack` in the request cycle):
  - LDA, STO, ADD, SUB: 2 cycles.
  - JMP, JGE, JNE: 2 cycles.
- Each memory wait cycle adds exactly 1 cycle to the state it occurs in.
- The request is held stable, with the same address select, until the ack cycle.
- Flags `N`/`Z` are sampled combinationally in the EXECUTE cycle of the jump. They reflect the Acc value committed by previous instructions.

## Structure
- Shared package `mu0_pkg`:
  - opcode constants (LDA…STP);
  - ALU mode constants (M_Y, M_ADD, M_INC, M_SUB);
  - state encoding (FETCH, EXECUTE, HALT).
- `mu0_datapath` uses the same ALU constants.
- One sub-module, `mu0_decode`: combinational, maps `F`, `N`, `Z` to the EXECUTE-state select/mode/request/enable vector.
- `mu0_control` holds the state register, ack gating, `Illegal` flag and `Instr_Count`.

## Test plan
- Reset release, Mem_Ack tied high, memory = {LDA 0x005, STP}, mem[5]=0x1234 -> FETCH, EXECUTE, FETCH, EXECUTE, then HALT by cycle 4; Acc_En pulsed once in cycle 1; Instr_Count=2.
- ADD with Mem_Ack delayed 3 cycles in both FETCH and EXECUTE -> Mem_Rd held for 4 cycles in each; IR_En, PC_En and Acc_En each pulse exactly once, in the ack cycle; M=01.
- JGE with N=1, then JGE with N=0 -> PC_En=0 in the first EXECUTE and 1 in the second; M=00, Y_sel=1 both times; no Mem_Rd/Mem_Wr in EXECUTE.
- STO 0x0FF -> Mem_Wr=1 with Addr_sel=1 and X_sel=0; Mem_Rd=0; no register enable.
- Opcode 0xA -> HALT; Illegal=1; Instr_Count unchanged. Toggling Mem_Ack in HALT produces no output change.
- Reset asserted while FETCH awaits ack -> all outputs 0 in the same cycle. After release: FETCH, Instr_Count=0, Illegal=0.

Source files
------------

// File: rtl/mu0_pkg.sv
// mu0_pkg: shared opcode, ALU-mode, state and control-vector definitions for MU0
package mu0_pkg;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] M_Y   = 2'b00;
    localparam logic [1:0] M_ADD = 2'b01;
    localparam logic [1:0] M_INC = 2'b10;
    localparam logic [1:0] M_SUB = 2'b11;

    typedef enum logic [1:0] {FETCH, EXECUTE, HALT} state_t;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] m;
        logic       mem_rd;
        logic       mem_wr;
    } ctrl_t;
endpackage

// File: rtl/mu0_decode.sv
// mu0_decode: maps opcode and flags to the EXECUTE-state control vector (enables before ack gating)
module mu0_decode
    import mu0_pkg::*;
(
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    output ctrl_t      ex
);
    always_comb begin
        ex = '0;
        case (F)
            OP_LDA: begin ex.addr_sel = 1'b1; ex.mem_rd = 1'b1; ex.m = M_Y; ex.acc_en = 1'b1; end
            OP_STO: begin ex.addr_sel = 1'b1; ex.mem_wr = 1'b1; end
            OP_ADD: begin ex.addr_sel = 1'b1; ex.mem_rd = 1'b1; ex.m = M_ADD; ex.acc_en = 1'b1; end
            OP_SUB: begin ex.addr_sel = 1'b1; ex.mem_rd = 1'b1; ex.m = M_SUB; ex.acc_en = 1'b1; end
            OP_JMP: begin ex.y_sel = 1'b1; ex.m = M_Y; ex.pc_en = 1'b1; end
            OP_JGE: begin ex.y_sel = 1'b1; ex.m = M_Y; ex.pc_en = ~N; end
            OP_JNE: begin ex.y_sel = 1'b1; ex.m = M_Y; ex.pc_en = ~Z; end
            default: ex = '0;
        endcase
    end
endmodule

// File: rtl/mu0_control.sv
// mu0_control: MU0 fetch/execute sequencer with memory handshake, halt, illegal flag and retire counter
module mu0_control
    import mu0_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  F,
    input  logic        N,
    input  logic        Z,
    input  logic        Mem_Ack,
    output logic        X_sel,
    output logic        Y_sel,
    output logic        Addr_sel,
    output logic        PC_En,
    output logic        IR_En,
    output logic        Acc_En,
    output logic [1:0]  M,
    output logic        Mem_Rd,
    output logic        Mem_Wr,
    output logic        Halted,
    output logic        Illegal,
    output logic [15:0] Instr_Count
);
    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [15:0] count_q, count_d;
    ctrl_t       ex, ctrl;
    logic        ex_mem, ex_stop, retire;

    mu0_decode u_decode (.F(F), .N(N), .Z(Z), .ex(ex));

    assign ex_mem  = ex.mem_rd | ex.mem_wr;
    assign ex_stop = (F == OP_STP) | F[3];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = Mem_Ack ? EXECUTE : FETCH;
            EXECUTE: state_d = ex_stop ? HALT : (ex_mem && !Mem_Ack) ? EXECUTE : FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        // STP retires; illegal opcodes do not
        retire    = (state_q == EXECUTE) && ((state_d == FETCH) || (F == OP_STP));
        illegal_d = illegal_q | ((state_q == EXECUTE) && F[3]);
        count_d   = count_q + 16'(retire);
    end

    always_comb begin
        ctrl = '0;
        if (state_q == FETCH) begin
            ctrl.x_sel  = 1'b1;
            ctrl.mem_rd = 1'b1;
            ctrl.m      = M_INC;
            ctrl.pc_en  = Mem_Ack;
            ctrl.ir_en  = Mem_Ack;
        end else if (state_q == EXECUTE) begin
            ctrl = ex;
            if (ex_mem && !Mem_Ack) begin
                ctrl.pc_en  = 1'b0;
                ctrl.ir_en  = 1'b0;
                ctrl.acc_en = 1'b0;
            end
        end
        // reset aborts any access combinationally, before the state register settles
        if (Reset)
            ctrl = '0;
    end

    assign {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Mem_Rd, Mem_Wr} = ctrl;
    assign Halted      = (state_q == HALT);
    assign Illegal     = illegal_q;
    assign Instr_Count = count_q;
endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: table-driven directed check of the MU0 control unit plus an async-reset sequence
module tb_mu0_control;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  F = 4'h0;
    logic        N = 1'b0;
    logic        Z = 1'b0;
    logic        Mem_Ack = 1'b0;
    logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Mem_Rd, Mem_Wr;
    logic [1:0]  M;
    logic        Halted, Illegal;
    logic [15:0] Instr_Count;

    mu0_control dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ack(Mem_Ack),
        .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .PC_En(PC_En),
        .IR_En(IR_En), .Acc_En(Acc_En), .M(M), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr),
        .Halted(Halted), .Illegal(Illegal), .Instr_Count(Instr_Count)
    );

    always #5 Clk = ~Clk;

    // {X_sel,Y_sel,Addr_sel,PC_En,IR_En,Acc_En,M[1:0],Mem_Rd,Mem_Wr}
    localparam logic [9:0] C_OFF   = 10'b0000000000;
    localparam logic [9:0] C_FACK  = 10'b1001101010;
    localparam logic [9:0] C_FWAIT = 10'b1000001010;
    localparam logic [9:0] C_LDA   = 10'b0010010010;
    localparam logic [9:0] C_STO   = 10'b0010000001;
    localparam logic [9:0] C_ADDW  = 10'b0010000110;
    localparam logic [9:0] C_ADD   = 10'b0010010110;
    localparam logic [9:0] C_SUB   = 10'b0010011110;
    localparam logic [9:0] C_JT    = 10'b0101000000;
    localparam logic [9:0] C_JNT   = 10'b0100000000;

    typedef struct {
        logic        rst;
        logic [3:0]  f;
        logic        n;
        logic        z;
        logic        ack;
        logic [9:0]  ctrl;
        logic        halted;
        logic        illegal;
        logic [15:0] cnt;
    } vec_t;

    vec_t vec[64];
    int   nv = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [9:0] ctrl_act;

    assign ctrl_act = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Mem_Rd, Mem_Wr};

    task automatic add(input logic r, input logic [3:0] f, input logic n, input logic z,
                       input logic a, input logic [9:0] c, input logic h, input logic il,
                       input logic [15:0] k);
        vec[nv] = '{r, f, n, z, a, c, h, il, k};
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // rst f n z ack ctrl halted illegal count
        add(1, 4'h0, 0, 0, 1, C_OFF,   0, 0, 16'd0);
        // LDA 5 ; STP with zero-wait memory
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd0);
        add(0, 4'h0, 0, 0, 1, C_LDA,   0, 0, 16'd0);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd1);
        add(0, 4'h7, 0, 0, 1, C_OFF,   0, 0, 16'd1);
        add(0, 4'h7, 0, 0, 1, C_OFF,   1, 0, 16'd2);
        add(1, 4'h0, 0, 0, 0, C_OFF,   0, 0, 16'd0);
        // ADD with three wait cycles in both phases
        add(0, 4'h0, 0, 0, 0, C_FWAIT, 0, 0, 16'd0);
        add(0, 4'h0, 0, 0, 0, C_FWAIT, 0, 0, 16'd0);
        add(0, 4'h0, 0, 0, 0, C_FWAIT, 0, 0, 16'd0);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd0);
        add(0, 4'h2, 0, 0, 0, C_ADDW,  0, 0, 16'd0);
        add(0, 4'h2, 0, 0, 0, C_ADDW,  0, 0, 16'd0);
        add(0, 4'h2, 0, 0, 0, C_ADDW,  0, 0, 16'd0);
        add(0, 4'h2, 0, 0, 1, C_ADD,   0, 0, 16'd0);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd1);
        // JGE N=1 not taken, JGE N=0 taken (ack ignored without request)
        add(0, 4'h5, 1, 0, 1, C_JNT,   0, 0, 16'd1);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd2);
        add(0, 4'h5, 0, 0, 0, C_JT,    0, 0, 16'd2);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd3);
        // JNE Z=1 not taken, JMP
        add(0, 4'h6, 0, 1, 1, C_JNT,   0, 0, 16'd3);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd4);
        add(0, 4'h4, 1, 1, 1, C_JT,    0, 0, 16'd4);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd5);
        // STO with one wait
        add(0, 4'h1, 0, 0, 0, C_STO,   0, 0, 16'd5);
        add(0, 4'h1, 0, 0, 1, C_STO,   0, 0, 16'd5);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd6);
        add(0, 4'h3, 0, 0, 1, C_SUB,   0, 0, 16'd6);
        add(0, 4'h0, 0, 0, 1, C_FACK,  0, 0, 16'd7);
        // illegal opcode, then Mem_Ack toggling in HALT
        add(0, 4'hA, 0, 0, 1, C_OFF,   0, 0, 16'd7);
        add(0, 4'hA, 0, 0, 1, C_OFF,   1, 1, 16'd7);
        add(0, 4'hA, 0, 0, 0, C_OFF,   1, 1, 16'd7);
        add(0, 4'h0, 0, 0, 1, C_OFF,   1, 1, 16'd7);
        add(1, 4'h0, 0, 0, 1, C_OFF,   0, 0, 16'd0);
        add(0, 4'h0, 0, 0, 0, C_FWAIT, 0, 0, 16'd0);

        for (int i = 0; i < nv; i++) begin
            @(negedge Clk);
            Reset = vec[i].rst; F = vec[i].f; N = vec[i].n; Z = vec[i].z; Mem_Ack = vec[i].ack;
            #2;
            check($sformatf("ctrl[%0d]", i), 32'(ctrl_act), 32'(vec[i].ctrl));
            check($sformatf("status[%0d]", i), {14'd0, Halted, Illegal, Instr_Count},
                  {14'd0, vec[i].halted, vec[i].illegal, vec[i].cnt});
        end

        // async reset while FETCH awaits ack, after one retired LDA
        @(negedge Clk); F = 4'h0; Mem_Ack = 1'b1;
        @(negedge Clk); F = 4'h0; Mem_Ack = 1'b1;
        @(negedge Clk); Mem_Ack = 1'b0;
        #2;
        check("pre_reset", {15'd0, Mem_Rd, Instr_Count}, {15'd0, 1'b1, 16'd1});
        Reset = 1'b1;
        #1;
        check("async_reset_ctrl", 32'(ctrl_act), 32'(C_OFF));
        check("async_reset_status", {14'd0, Halted, Illegal, Instr_Count}, 32'd0);
        @(negedge Clk); Reset = 1'b0;
        #2;
        check("post_reset_ctrl", 32'(ctrl_act), 32'(C_FWAIT));
        check("post_reset_status", {14'd0, Halted, Illegal, Instr_Count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
